// File: rtl/keypad_code_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_code_display_if
//  Description : Bundle between the keypad code storage (shift-register
//                array / output circuit) and the multiplexed 7-segment
//                display driver. The storage side drives the code and the
//                display controls; the display side returns the pin drive.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_code_display_if;

    // Code and display controls, produced by the storage side
    logic [31:0] digits;      // digit 1 in [31:28] ... digit 8 in [3:0]
    logic [3:0]  count;       // digits entered, values above 8 mean 8
    logic        mask;        // show '-' instead of digit values
    logic        alarm;       // blink every lit position
    logic        unlocked;    // light the decimal point on lit positions

    // Display pin drive, produced by the display driver
    logic [6:0]  seg;         // {a,b,c,d,e,f,g}, active-high
    logic        dp;          // decimal point, active-high
    logic [7:0]  an;          // one-hot position enable, an[0] = digit 1
    logic        frame_done;  // one-cycle pulse at the start of each scan

    // Storage / code source side
    modport master (
        output digits,
        output count,
        output mask,
        output alarm,
        output unlocked,
        input  seg,
        input  dp,
        input  an,
        input  frame_done
    );

    // Display driver side
    modport slave (
        input  digits,
        input  count,
        input  mask,
        input  alarm,
        input  unlocked,
        output seg,
        output dp,
        output an,
        output frame_done
    );

endinterface : keypad_code_display_if
`default_nettype wire

// File: rtl/keypad_code_display.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_code_display
//  Description : Time-multiplexed 8-position 7-segment driver for the
//                8-digit BCD lock code. Each position is lit for DIV
//                cycles; supports masking, blanking of unentered
//                positions, alarm blink and an "unlocked" decimal point.
//                All outputs are registered one stage behind the slot
//                counter, so every output comes straight from a flop.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_code_display #(
    parameter int DIV        = 4,   // cycles per position, legal 2..1024
    parameter int BLINK_BITS = 3    // frame counter width, blink period 2^N frames
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    keypad_code_display_if.slave  bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int PRE_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0] c_pre_last  = PRE_W'(DIV - 1);
    localparam logic [2:0]       c_slot_last = 3'd7;
    localparam logic [3:0]       c_max_count = 4'd8;

    // Segment glyphs, ordered {a,b,c,d,e,f,g}
    localparam logic [6:0] c_seg_0     = 7'b1111110;
    localparam logic [6:0] c_seg_1     = 7'b0110000;
    localparam logic [6:0] c_seg_2     = 7'b1101101;
    localparam logic [6:0] c_seg_3     = 7'b1111001;
    localparam logic [6:0] c_seg_4     = 7'b0110011;
    localparam logic [6:0] c_seg_5     = 7'b1011011;
    localparam logic [6:0] c_seg_6     = 7'b1011111;
    localparam logic [6:0] c_seg_7     = 7'b1110000;
    localparam logic [6:0] c_seg_8     = 7'b1111111;
    localparam logic [6:0] c_seg_9     = 7'b1111011;
    localparam logic [6:0] c_seg_err   = 7'b1001111;  // 'E' for non-BCD nibbles
    localparam logic [6:0] c_seg_dash  = 7'b0000001;  // masked digit
    localparam logic [6:0] c_seg_blank = 7'b0000000;

    // ------------------------------------------------------------------------
    // BCD to 7-segment decode; anything outside 0..9 shows 'E'
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'd0:    glyph = c_seg_0;
            4'd1:    glyph = c_seg_1;
            4'd2:    glyph = c_seg_2;
            4'd3:    glyph = c_seg_3;
            4'd4:    glyph = c_seg_4;
            4'd5:    glyph = c_seg_5;
            4'd6:    glyph = c_seg_6;
            4'd7:    glyph = c_seg_7;
            4'd8:    glyph = c_seg_8;
            4'd9:    glyph = c_seg_9;
            default: glyph = c_seg_err;
        endcase
        return glyph;
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [PRE_W-1:0]      r_pre;          // cycles spent in the current slot
    logic [2:0]            r_slot;         // position being prepared
    logic [BLINK_BITS-1:0] r_frm;          // frame counter, MSB drives blink
    logic                  r_wrap;         // last slot ended on the previous edge
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [7:0]            r_an;
    logic                  r_frame_done;

    // ------------------------------------------------------------------------
    // Combinational next-output path
    // ------------------------------------------------------------------------
    logic                  w_pre_last;
    logic                  w_slot_end_frame;
    logic [3:0]            w_eff_count;
    logic [7:0][3:0]       w_nibbles;
    logic [3:0]            w_nibble;
    logic                  w_enabled;
    logic                  w_blink_off;
    logic                  w_lit;
    logic [6:0]            w_seg_next;
    logic [7:0]            w_an_next;
    logic                  w_dp_next;

    assign w_pre_last       = (r_pre == c_pre_last);
    assign w_slot_end_frame = w_pre_last && (r_slot == c_slot_last);

    // Digit 1 sits in the top nibble, so slot s reads packed index 7-s (= ~s)
    assign w_nibbles = bus.digits;
    assign w_nibble  = w_nibbles[~r_slot];

    // Counts above 8 saturate; a position is shown only once it was entered
    assign w_eff_count = (bus.count > c_max_count) ? c_max_count : bus.count;
    assign w_enabled   = ({1'b0, r_slot} < w_eff_count);

    // Alarm darkens the second half of each blink period
    assign w_blink_off = bus.alarm && r_frm[BLINK_BITS-1];
    assign w_lit       = w_enabled && !w_blink_off;

    // Glyph selection for the slot being prepared
    always_comb begin
        w_seg_next = c_seg_blank;
        if (w_lit) begin
            if (bus.mask) begin
                w_seg_next = c_seg_dash;
            end else begin
                w_seg_next = f_decode(w_nibble);
            end
        end
    end

    // A single shifted bit keeps the enable one-hot by construction
    assign w_an_next = w_lit ? (8'd1 << r_slot) : 8'd0;
    assign w_dp_next = w_lit && bus.unlocked;

    // ------------------------------------------------------------------------
    // Scan counters: prescaler, slot and frame
    // ------------------------------------------------------------------------
    // Advance the prescaler each cycle, the slot at the end of each dwell
    // and the frame counter when the last slot finishes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_slot <= '0;
            r_frm  <= '0;
        end else begin
            if (w_pre_last) begin
                r_pre  <= '0;
                r_slot <= r_slot + 3'd1;
            end else begin
                r_pre  <= r_pre + PRE_W'(1);
            end
            if (w_slot_end_frame) begin
                r_frm <= r_frm + BLINK_BITS'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    // Register the display drive one stage behind the slot counter so the
    // pins never see combinational glitches from input or slot changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= c_seg_blank;
            r_dp  <= 1'b0;
            r_an  <= 8'd0;
        end else begin
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
            r_an  <= w_an_next;
        end
    end

    // Delay the end-of-frame strobe by one edge so the pulse coincides with
    // the first output cycle of slot 0; nothing is pending after reset, so
    // release itself never produces a pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrap       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_wrap       <= w_slot_end_frame;
            r_frame_done <= r_wrap;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;

endmodule : keypad_code_display
`default_nettype wire

// File: tb/tb_keypad_code_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_code_display
//  Description : Self-checking bench for keypad_code_display. Expected
//                outputs are derived from the number of edges since reset
//                release (slot/frame by division) and the inputs present
//                at each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_code_display;

    localparam int DIV = 4;
    localparam int BB  = 3;
    localparam int FRAME = 8 * DIV;

    logic clk;
    logic rst_n;
    int   k;          // edges taken with reset released
    int   n_checks;
    int   n_errors;

    keypad_code_display_if bus ();

    keypad_code_display #(
        .DIV        (DIV),
        .BLINK_BITS (BB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Segment glyphs as listed for digits 0..9, 'E' otherwise
    function automatic logic [6:0] glyph(input int n);
        case (n)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b1001111;
        endcase
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s (k=%0d): observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Reference: after edge k the outputs show slot ((k-1)/DIV)%8 of frame
    // ((k-1)/FRAME), using the inputs that were present at that edge
    task automatic check_all(input string tag);
        int s, f, n, eff;
        bit lit;
        logic [6:0] es;
        logic [7:0] ean;
        bit edp, efd;
        if (k == 0) begin
            es = '0; ean = '0; edp = 0; efd = 0;
        end else begin
            s   = ((k - 1) / DIV) % 8;
            f   = ((k - 1) / FRAME) % (1 << BB);
            eff = (bus.count > 8) ? 8 : int'(bus.count);
            n   = int'((bus.digits >> (28 - 4 * s)) & 32'hF);
            lit = (s < eff) && !(bus.alarm && (f >= (1 << (BB - 1))));
            ean = lit ? 8'(1 << s) : 8'd0;
            es  = !lit ? 7'd0 : (bus.mask ? 7'b0000001 : glyph(n));
            edp = lit && bus.unlocked;
            efd = (k > 1) && (((k - 1) % FRAME) == 0);
        end
        cmp({tag, ".an"},  32'(bus.an),  32'(ean));
        cmp({tag, ".seg"}, 32'(bus.seg), 32'(es));
        cmp({tag, ".dp"},  32'(bus.dp),  32'(edp));
        cmp({tag, ".frame_done"}, 32'(bus.frame_done), 32'(efd));
        cmp({tag, ".onehot"}, 32'($countones(bus.an) <= 1), 32'd1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) k++;
        else       k = 0;
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) tick(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        k     = 0;
        for (int i = 0; i < 3; i++) tick("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        n_checks = 0;
        n_errors = 0;
        k        = 0;
        rst_n    = 1'b0;
        bus.digits   = 32'h21935488;
        bus.count    = 4'd8;
        bus.mask     = 1'b0;
        bus.alarm    = 1'b0;
        bus.unlocked = 1'b0;

        // Reset and basic scan of the reference code
        do_reset();
        tick("scan");
        cmp("scan.first_an",  32'(bus.an),  32'h01);
        cmp("scan.first_seg", 32'(bus.seg), 32'b1101101);
        run("scan", 2 * FRAME + 4);

        // Partial entry and saturated count, random digits
        bus.digits = $urandom();
        bus.count  = 4'd3;
        run("count3", FRAME);
        bus.count  = 4'd12;
        run("count12", FRAME);
        bus.count  = 4'd0;
        run("count0", FRAME);

        // Mask, then an invalid BCD leading digit
        bus.count  = 4'd8;
        bus.mask   = 1'b1;
        bus.digits = $urandom();
        run("mask", FRAME);
        bus.mask   = 1'b0;
        bus.digits = {4'hC, 28'($urandom())};
        run("bad_bcd", FRAME);

        // Alarm blink over more than one blink period, from a clean frame 0
        do_reset();
        bus.alarm  = 1'b1;
        bus.digits = $urandom();
        run("alarm", 9 * FRAME);

        // Drop alarm in the middle of a dark frame 5
        found = 0;
        for (int i = 0; i < 10 * FRAME && !found; i++) begin
            tick("alarm_seek");
            if ((((k - 1) / FRAME) % 8 == 5) && (((k - 1) / DIV) % 8 == 3) && ((k - 1) % DIV == 1))
                found = 1;
        end
        cmp("alarm.seek_found", 32'(found), 32'd1);
        cmp("alarm.dark_before_release", 32'(bus.an), 32'd0);
        bus.alarm = 1'b0;
        tick("alarm_drop");
        cmp("alarm.lit_after_release", 32'(bus.an != 8'd0), 32'd1);
        run("alarm_off", FRAME);

        // Unlocked indicator with two entered digits
        bus.unlocked = 1'b1;
        bus.count    = 4'd2;
        run("unlocked", 2 * FRAME);

        // Random inputs changing every cycle, including mid-slot
        for (int i = 0; i < 6 * FRAME; i++) begin
            bus.digits   = $urandom();
            bus.count    = 4'($urandom_range(0, 15));
            bus.mask     = 1'($urandom_range(0, 3) == 0);
            bus.alarm    = 1'($urandom_range(0, 1));
            bus.unlocked = 1'($urandom_range(0, 1));
            tick("random");
        end

        // Asynchronous reset during slot 5
        bus.count = 4'd8; bus.mask = 1'b0; bus.alarm = 1'b0; bus.unlocked = 1'b1;
        bus.digits = $urandom();
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            tick("async_seek");
            if (((k - 1) / DIV) % 8 == 5) found = 1;
        end
        cmp("async.seek_found", 32'(found), 32'd1);
        cmp("async.lit_before", 32'(bus.an), 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async.an_clear",  32'(bus.an),  32'd0);
        cmp("async.seg_clear", 32'(bus.seg), 32'd0);
        cmp("async.dp_clear",  32'(bus.dp),  32'd0);
        cmp("async.fd_clear",  32'(bus.frame_done), 32'd0);
        k = 0;
        run("async_hold", 2);
        @(negedge clk);
        rst_n = 1'b1;
        tick("async_resume");
        cmp("async.resume_an", 32'(bus.an), 32'h01);
        run("async_resume", 2 * FRAME + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_keypad_code_display
`default_nettype wire

// File: doc/keypad_code_display.md
# keypad_code_display

Decoder-side counterpart of the keypad input encoder. Takes the 8-digit BCD code held in the lock's user-input (or setpoint) shift-register array and drives a time-multiplexed, 8-position 7-segment display. Supports masking (dash per entered digit), blanking of unentered positions, alarm blink and an "unlocked" decimal-point indicator. Sits between the shift-register array / output circuit and the board display pins.

## Interface

- `DIV`, default 4: clock cycles each digit position stays lit; legal values are 2..1024.
- `BLINK_BITS`, default 3: width of the frame counter. The alarm blink period is 2^BLINK_BITS frames.
- `clk`, input, 1: single clock; every register is on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset; release is synchronous to `clk`.
- `digits`, input, 32: stored code. `digits[31:28]` is digit 1 (first entered) and `digits[3:0]` is digit 8.
- `count`, input, 4: number of digits entered. Values above 8 are treated as 8.
- `mask`, input, 1: when 1, every entered position shows '-' instead of its digit.
- `alarm`, input, 1: when 1, all lit positions blink.
- `unlocked`, input, 1: when 1, the decimal point is lit on every lit position.
- `seg`, output, 7: segment drive {a,b,c,d,e,f,g}, active-high, registered.
- `dp`, output, 1: decimal point, active-high, registered.
- `an`, output, 8: position enable, one-hot, active-high, registered. `an[0]` is digit 1. All zeros means blanked.
- `frame_done`, output, 1: one-cycle pulse marking the end of each full 8-position scan, registered.

## Operation

- **Prescaler `pre`:** counts 0..DIV-1 and wraps.
- **Slot counter `slot`:** 3 bits; advances when `pre == DIV-1`; wraps 7→0.
- **Frame counter `frm`:** BLINK_BITS bits; increments when slot 7 ends; wraps freely.
- **Per-cycle next-output computation for slot s:**
  - Nibble: n = `digits[31-4s -: 4]`.
  - Enabled when s < min(`count`, 8).
  - Blink-off when `alarm` = 1 and `frm` MSB = 1.
  - Lit = enabled AND NOT blink-off.
  - `an` = one-hot(s) if lit, otherwise 0.
  - `seg`:
    - 0 if not lit.
    - 0000001 ('-') if lit and `mask` = 1.
    - Otherwise decode n: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
    - n = 10..15 gives 1001111 ('E').
  - `dp` = lit AND `unlocked`.
- **No input latching:** `digits`, `count`, `mask`, `alarm` and `unlocked` are sampled every cycle, so a change shows on outputs at the next edge, even mid-slot.
- **`count` = 0:** `an` stays 0 permanently; counters keep running and `frame_done` keeps pulsing.
- **Reset mid-scan:** everything clears immediately. The scan restarts at slot 0 with `frm` = 0.

## Timing

- **Reset values while `rst_n` = 0:**
  - `pre` = 0, `slot` = 0, `frm` = 0.
  - `seg` = 0, `dp` = 0, `an` = 0, `frame_done` = 0.
- **First update:** the first rising edge after release loads the slot 0 outputs.
- **Output latency:** outputs are one register stage behind `slot`. Slot k is presented for exactly DIV consecutive cycles.
- **Frame length:** 8·DIV cycles.
- **`frame_done`:** high for the single cycle in which the outputs first show slot 0 of a new frame. The first pulse comes 8·DIV cycles after the first output update; there is no pulse at reset release.
- **Blink:** the `frm` MSB toggles every 2^(BLINK_BITS-1) frames. With `alarm` held at 1, positions are lit for 2^(BLINK_BITS-1) frames and then dark for the same number.
- **Alarm release:** deasserting `alarm` restores lit positions at the next edge, whatever the phase of `frm`.
- **Glitch-free position enable:** `an` never has more than one bit set in any cycle, including slot transitions and input changes.

## Test plan

All scenarios use DIV = 4 and BLINK_BITS = 3.

1. **Reset / scan sequence.**
   - Stimulus: hold `rst_n` = 0 for 3 cycles; `digits` = 32'h21935488, `count` = 8, other controls 0.
   - Required: `an`, `seg`, `dp`, `frame_done` all 0 during reset.
   - Required after release: `an` steps 01, 02, 04 … 80, each for 4 cycles.
   - Required `seg` sequence: 1101101, 0110000, 1111011, 1111001, 1011011, 0110011, 1111111, 1111111.
   - Required: `frame_done` pulses every 32 cycles.
2. **Partial entry.**
   - `count` = 3 → only `an` = 01, 02, 04 appear; slots 3..7 show `an` = 0 and `seg` = 0.
   - `count` = 12 → behaves exactly like `count` = 8.
3. **Mask and invalid BCD.**
   - `mask` = 1, `count` = 8 → every slot shows `seg` = 0000001.
   - `mask` = 0 with `digits[31:28]` = 4'hC → slot 0 shows 1001111.
4. **Alarm blink.**
   - Stimulus: `alarm` = 1, `count` = 8.
   - Required: frames 0..3 lit, frames 4..7 have `an` = 0, then the pattern repeats.
   - Stimulus: drop `alarm` in the middle of frame 5 → `an` is nonzero at the very next slot edge.
5. **Unlocked indicator.**
   - `unlocked` = 1, `count` = 2 → `dp` = 1 exactly while `an` = 01 or 02, and 0 otherwise.
6. **Asynchronous reset mid-scan.**
   - Stimulus: assert `rst_n` = 0 during slot 5, asynchronously between edges.
   - Required: outputs clear without waiting for a clock edge.
   - Required after release: the scan resumes at `an` = 01, and the first `frame_done` comes 32 cycles after the first output update.
